// File: rtl/y86_pkg.sv
// y86_pkg -- shared constants and types for the Y86-64 fetch stage.
//   Instruction codes (IHALT..IPOPQ), status codes (AOK/HLT/ADR/INS),
//   the fetch FSM state type, the "no register" id, and decode helpers.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    STOP  = 2'd3
  } fetch_state_t;

  function automatic logic need_regids(input logic [3:0] icode);
    return (icode == IRRMOVQ) || (icode == IIRMOVQ) || (icode == IRMMOVQ) ||
           (icode == IMRMOVQ) || (icode == IOPQ)    || (icode == IPUSHQ)  ||
           (icode == IPOPQ);
  endfunction

  function automatic logic need_valc(input logic [3:0] icode);
    return (icode == IIRMOVQ) || (icode == IRMMOVQ) || (icode == IMRMOVQ) ||
           (icode == IJXX)    || (icode == ICALL);
  endfunction

endpackage

// File: rtl/instr_split.sv
// instr_split -- combinational decode of one 10-byte Y86-64 instruction.
//   instr : 80-bit little-endian instruction bytes (byte 0 in [7:0])
//   i_ok  : address was in range
//   pc    : address of the instruction
//   icode/ifun/rA/rB/valC : decoded fields
//   valP  : address of the following instruction (pc when stat != AOK)
//   stat  : ADR > INS > HLT > AOK priority
module instr_split
  import y86_pkg::*;
(
  input  logic [79:0] instr,
  input  logic        i_ok,
  input  logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat
);

  logic nr;
  logic nv;
  logic invalid;

  always_comb begin
    icode = instr[7:4];
    ifun  = instr[3:0];
    nr    = need_regids(icode);
    nv    = need_valc(icode);
    rA    = nr ? instr[15:12] : RNONE;
    rB    = nr ? instr[11:8]  : RNONE;
    // Constant word follows the register byte when one is present.
    valC  = nv ? (nr ? instr[79:16] : instr[71:8]) : 64'd0;

    if (icode > IPOPQ)
      invalid = 1'b1;
    else if (icode == IOPQ)
      invalid = (ifun > 4'd3);
    else if ((icode == IRRMOVQ) || (icode == IJXX))
      invalid = (ifun > 4'd6);
    else
      invalid = (ifun != 4'd0);

    if (!i_ok)
      stat = ADR;
    else if (invalid)
      stat = INS;
    else if (icode == IHALT)
      stat = HLT;
    else
      stat = AOK;

    // A faulting instruction does not advance the PC.
    if (stat == AOK)
      valP = pc + 64'd1 + {63'd0, nr} + (nv ? 64'd8 : 64'd0);
    else
      valP = pc;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- Y86-64 instruction fetch with a valid/ready output handshake.
//   clock, reset         : single clock, synchronous active-high reset
//   iaddr / instr / i_ok : instruction memory port (data one cycle after iaddr)
//   f_ready              : downstream accepts the presented instruction
//   pc_load / pc_next    : redirect applied only on an AOK handshake
//   f_valid, f_pc, icode, ifun, rA, rB, valC, valP, f_stat : fetched instruction
//   icount               : accepted AOK instructions (only with FETCH_ICOUNT_EN)
//
// state | meaning
// FETCH | iaddr = pc presented to memory
// WAIT  | memory data valid, decoded fields captured
// HOLD  | f_valid = 1, wait for f_ready
// STOP  | non-AOK instruction accepted; frozen until reset
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] iaddr,
  input  logic [79:0] instr,
  input  logic        i_ok,
  input  logic        f_ready,
  input  logic        pc_load,
  input  logic [63:0] pc_next,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  f_stat
`ifdef FETCH_ICOUNT_EN
  ,
  output logic [31:0] icount
`endif
);

  fetch_state_t state, state_nxt;
  logic [63:0]  pc;
  logic         accept_ok;

  logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
  logic [63:0] d_valc, d_valp;
  logic [2:0]  d_stat;

  instr_split u_split (
    .instr (instr),
    .i_ok  (i_ok),
    .pc    (pc),
    .icode (d_icode),
    .ifun  (d_ifun),
    .rA    (d_ra),
    .rB    (d_rb),
    .valC  (d_valc),
    .valP  (d_valp),
    .stat  (d_stat)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: state_nxt = WAIT;
      WAIT:  state_nxt = HOLD;
      HOLD:  if (f_ready) state_nxt = (f_stat == AOK) ? FETCH : STOP;
      STOP:  state_nxt = STOP;
    endcase
  end

  assign accept_ok = (state == HOLD) && f_ready && (f_stat == AOK);
  assign f_valid   = (state == HOLD);
  // pc only moves on an AOK handshake, so iaddr is naturally frozen in STOP.
  assign iaddr     = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= RESET_PC;
      f_pc   <= 64'd0;
      icode  <= 4'd0;
      ifun   <= 4'd0;
      rA     <= RNONE;
      rB     <= RNONE;
      valC   <= 64'd0;
      valP   <= 64'd0;
      f_stat <= AOK;
    end else begin
      if (state == WAIT) begin
        f_pc   <= pc;
        icode  <= d_icode;
        ifun   <= d_ifun;
        rA     <= d_ra;
        rB     <= d_rb;
        valC   <= d_valc;
        valP   <= d_valp;
        f_stat <= d_stat;
      end
      if (accept_ok)
        pc <= pc_load ? pc_next : valP;
    end
  end

`ifdef FETCH_ICOUNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      icount <= 32'd0;
    else if (accept_ok && (icount != 32'hFFFF_FFFF))
      icount <= icount + 32'd1;
  end
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port iaddr  output  64  instruction address to the memory instruction port.
REQ-005 SHALL have port instr  input  80  10 instruction bytes, little-endian, valid one cycle after iaddr.
REQ-006 SHALL have port i_ok  input  1  instruction address in range, same timing as instr.
REQ-007 SHALL have port f_ready  input  1  downstream accepts the fetched instruction.
REQ-008 SHALL have port pc_load  input  1  override the next PC with pc_next.
REQ-009 SHALL have port pc_next  input  64  redirect PC for jumps, calls and returns.
REQ-010 SHALL have ports f_valid (1), f_pc (64), icode (4), ifun (4), rA (4), rB (4), valC (64), valP (64) and f_stat (3), all outputs.

Function
REQ-011 The FSM SHALL have states FETCH, WAIT, HOLD and STOP.
REQ-012 FETCH: drive iaddr=pc; go to WAIT next cycle.
REQ-013 WAIT: capture decoded fields from instr/i_ok into output registers; go to HOLD.
REQ-014 HOLD: f_valid=1; outputs stable while f_ready=0.
REQ-015 HOLD with f_ready=1 and f_stat==AOK: go to FETCH; pc <= pc_load ? pc_next : valP.
REQ-016 HOLD with f_ready=1 and f_stat!=AOK: go to STOP.
REQ-017 STOP: f_valid=0, iaddr frozen, pc_load ignored; leave only by reset.
REQ-018 pc_load SHALL be ignored outside a HOLD handshake cycle.
REQ-019 Decode: icode=instr[7:4], ifun=instr[3:0]; rA/rB=instr[15:12]/[11:8] when need_regids, else 4'hF.
REQ-020 need_regids SHALL be true for icode 2,3,4,5,6,A,B; need_valC SHALL be true for icode 3,4,5,7,8.
REQ-021 valC SHALL come from bytes 2..9 if need_regids, else bytes 1..8; it is 0 when need_valC is false.
REQ-022 valP SHALL equal pc + 1 + need_regids + 8*need_valC, modulo 2^64 (wraps silently).
REQ-023 Invalid instruction: icode > B; ifun > 3 for icode 6; ifun > 6 for icode 2 or 7; ifun != 0 for any other icode.
REQ-024 f_stat SHALL use priority ADR(3) if !i_ok, then INS(4) if invalid, then HLT(2) if icode 0, else AOK(1).
REQ-025 When f_stat!=AOK, valP SHALL equal f_pc; the other fields are reported as decoded.
REQ-026 Throughput SHALL be one instruction per 3 cycles with f_ready held high.

Reset
REQ-027 Reset in any state SHALL force state FETCH, pc=RESET_PC and iaddr=RESET_PC.
REQ-028 Reset SHALL clear f_valid=0, f_pc=0, icode=ifun=0, rA=rB=F, valC=valP=0 and f_stat=AOK.
REQ-029 Reset SHALL take priority over f_ready and pc_load in the same cycle.

Configuration
REQ-030 With FETCH_ICOUNT_EN defined: add output icount (32), cleared on reset, incremented on each HOLD handshake with f_stat==AOK, saturating at all-ones.
REQ-031 Without FETCH_ICOUNT_EN: no icount port, no counter logic.

Structure
REQ-032 Package y86_pkg SHALL hold icode constants (IHALT..IPOPQ), stat codes (AOK, HLT, ADR, INS), the FSM state typedef and RNONE=4'hF.
REQ-033 Sub-module instr_split SHALL be combinational: it takes instr, i_ok and pc and produces icode, ifun, rA, rB, valC, valP, stat.

Verification
REQ-034 Reset, pc 0, instr bytes 30 F3 00 01 00 00 00 00 00 00 -> f_valid at cycle 2: icode 3, ifun 0, rA F, rB 3, valC 0x100, valP 0x0A, stat AOK.
REQ-035 Byte 00 at pc 0x14 -> stat HLT; after handshake, state STOP with f_valid=0 and iaddr held at 0x14.
REQ-036 i_ok=0 with any bytes -> stat ADR and valP=f_pc; byte C0 -> INS; byte 27 -> INS; byte 26 -> AOK.
REQ-037 f_ready low for 5 cycles in HOLD -> all outputs unchanged; then f_ready=1 with pc_load=1 and pc_next=0x40 -> next iaddr 0x40.
REQ-038 Reset asserted during WAIT -> next cycle FETCH, iaddr=RESET_PC, f_valid=0; pc=FFFF_FFFF_FFFF_FFFF with byte 10 -> valP 0.
